hud_display: RTL



---
 rtl/hud_pkg.sv | 57 +++++
 rtl/bin2bcd_seq.sv | 91 +++++++++
 rtl/hud_display.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/hud_pkg.sv
// hud_pkg: shared constants for the HUD display slice.
// Holds the game-state encodings, active-low 7-segment glyphs (bit 0 = CA ..
// bit 6 = CG), digit-slot indices and the converter state type.
package hud_pkg;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PLAY = 3'd1;
   localparam logic [2:0] ST_OVER = 3'd2;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [2:0] IDX_TIME_TENS  = 3'd7;
   localparam logic [2:0] IDX_TIME_UNITS = 3'd6;
   localparam logic [2:0] IDX_BLANK_HI   = 3'd5;
   localparam logic [2:0] IDX_BLANK_LO   = 3'd4;
   localparam logic [2:0] IDX_SC_THOU    = 3'd3;
   localparam logic [2:0] IDX_SC_HUND    = 3'd2;
   localparam logic [2:0] IDX_SC_TENS    = 3'd1;
   localparam logic [2:0] IDX_SC_UNITS   = 3'd0;

   typedef enum logic [1:0] {
      CV_IDLE  = 2'd0,
      CV_SHIFT = 2'd1,
      CV_DONE  = 2'd2
   } cv_state_e;

   // Maps one BCD digit to its glyph; non-decimal codes render blank
   function automatic logic [6:0] digitToSeg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// One shift per clock; the first shift happens on the start edge, so done_o
// rises WIDTH cycles after the start pulse and bcd_o is valid while done_o
// is high. busy_o covers every non-idle cycle including the done cycle.
module bin2bcd_seq
   import hud_pkg::*;
#(
   parameter int WIDTH  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start_i,
   input  logic [WIDTH-1:0]      bin_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4*DIGITS-1:0]   bcd_o
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   cv_state_e         state_q, state_d;
   logic [BW-1:0]     bcd_q, bcd_d;
   logic [WIDTH-1:0]  bin_q, bin_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [BW-1:0]     bcdAdj;

   // Adds 3 to every BCD digit that is 5 or more, ahead of the next shift
   function automatic logic [BW-1:0] addThree(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (r[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   // State and datapath registers; reset abandons any conversion in flight
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= CV_IDLE;
         bcd_q   <= '0;
         bin_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         bin_q   <= bin_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: start kicks off shifting, the last shift lands in DONE
   always_comb begin
      state_d = state_q;
      case (state_q)
         CV_IDLE:  if (start_i) state_d = CV_SHIFT;
         CV_SHIFT: if (cnt_q == CW'(WIDTH - 1)) state_d = CV_DONE;
         CV_DONE:  state_d = CV_IDLE;
         default:  state_d = CV_IDLE;
      endcase
   end

   // Datapath: load plus first shift on start, then one adjust-and-shift per cycle
   always_comb begin
      bcd_d  = bcd_q;
      bin_d  = bin_q;
      cnt_d  = cnt_q;
      bcdAdj = addThree(bcd_q);
      if (state_q == CV_IDLE && start_i) begin
         bcd_d = {{(BW-1){1'b0}}, bin_i[WIDTH-1]};
         bin_d = {bin_i[WIDTH-2:0], 1'b0};
         cnt_d = CW'(1);
      end else if (state_q == CV_SHIFT) begin
         bcd_d = {bcdAdj[BW-2:0], bin_q[WIDTH-1]};
         bin_d = {bin_q[WIDTH-2:0], 1'b0};
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Outputs decoded from the state register
   always_comb begin
      busy_o = (state_q != CV_IDLE);
      done_o = (state_q == CV_DONE);
      bcd_o  = bcd_q;
   end

endmodule

// File: rtl/hud_display.sv
// hud_display: drives the 8-digit multiplexed 7-segment HUD.
// Left two digits show remaining seconds, right four show the score (BCD via
// bin2bcd_seq, refreshed once per frame). IDLE shows the game length and
// dashes, PLAY live values, OVER a blinking score.
// Optional build macro HUD_ZERO_BLANK_EN blanks leading score zeros and a
// zero time-tens digit.
module hud_display
   import hud_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 50000000,
   parameter int GAME_LEN  = 60
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [2:0]  game_state,
   input  logic [7:0]  timer,
   input  logic [13:0] score,
   output logic [7:0]  an,
   output logic [7:0]  seg
);

   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = $clog2(BLINK_DIV);
   localparam int REM_MAX = GAME_LEN - 1;
   localparam logic [3:0] GAME_TENS  = 4'(GAME_LEN / 10);
   localparam logic [3:0] GAME_UNITS = 4'(GAME_LEN % 10);

`ifdef HUD_ZERO_BLANK_EN
   localparam bit ZERO_BLANK = 1'b1;
`else
   localparam bit ZERO_BLANK = 1'b0;
`endif

   logic [SCAN_W-1:0]  scanCnt_q, scanCnt_d;
   logic [2:0]         digitIdx_q, digitIdx_d;
   logic               scanWrap;

   logic [BLINK_W-1:0] blinkCnt_q, blinkCnt_d;
   logic               blinkPhase_q, blinkPhase_d;
   logic               inPlay, inOver;

   logic [7:0]         remSec;
   logic [3:0]         timeTens_q, timeTens_d;
   logic [3:0]         timeUnits_q, timeUnits_d;

   logic [13:0]        scoreClamped;
   logic               convStart, convBusy, convDone;
   logic [15:0]        convBcd;
   logic [15:0]        snap_q, snap_d;

   logic [3:0]         showTens, showUnits;
   logic [3:0]         scoreDigit;
   logic               leadZero;
   logic [6:0]         glyph;
   logic [7:0]         an_q, seg_q;

   assign inPlay = (game_state == ST_PLAY);
   assign inOver = (game_state == ST_OVER);

   // Scan counter and digit index registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         scanCnt_q  <= '0;
         digitIdx_q <= '0;
      end else begin
         scanCnt_q  <= scanCnt_d;
         digitIdx_q <= digitIdx_d;
      end
   end

   // Digit slot advances each time the scan counter wraps
   always_comb begin
      scanWrap   = (scanCnt_q == SCAN_W'(SCAN_DIV - 1));
      scanCnt_d  = scanWrap ? '0 : scanCnt_q + SCAN_W'(1);
      digitIdx_d = scanWrap ? digitIdx_q + 3'd1 : digitIdx_q;
   end

   // Blink counter and phase registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         blinkCnt_q   <= '0;
         blinkPhase_q <= 1'b0;
      end else begin
         blinkCnt_q   <= blinkCnt_d;
         blinkPhase_q <= blinkPhase_d;
      end
   end

   // Blink runs only in OVER; held at zero elsewhere so every entry starts visible
   always_comb begin
      blinkCnt_d   = '0;
      blinkPhase_d = 1'b0;
      if (inOver) begin
         if (blinkCnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blinkCnt_d   = '0;
            blinkPhase_d = ~blinkPhase_q;
         end else begin
            blinkCnt_d   = blinkCnt_q + BLINK_W'(1);
            blinkPhase_d = blinkPhase_q;
         end
      end
   end

   // Remaining seconds split into tens/units, clamped at zero once time runs out
   always_comb begin
      remSec = 8'd0;
      if (timer <= 8'(REM_MAX)) begin
         remSec = 8'(REM_MAX) - timer;
      end
      timeTens_d  = 4'(remSec / 8'd10);
      timeUnits_d = 4'(remSec % 8'd10);
   end

   // Time digit pipeline register; pure data, reloaded every cycle so no reset needed
   always_ff @(posedge clk) begin
      timeTens_q  <= timeTens_d;
      timeUnits_q <= timeUnits_d;
   end

   assign scoreClamped = (score > 14'd9999) ? 14'd9999 : score;
   assign convStart    = scanWrap && (digitIdx_q == IDX_TIME_TENS) && !convBusy;

   bin2bcd_seq #(
      .WIDTH  (14),
      .DIGITS (4)
   ) uBcd (
      .clk     (clk),
      .rstn    (rstn),
      .start_i (convStart),
      .bin_i   (scoreClamped),
      .busy_o  (convBusy),
      .done_o  (convDone),
      .bcd_o   (convBcd)
   );

   // Score snapshot captures the converter result on its done cycle
   always_comb begin
      snap_d = convDone ? convBcd : snap_q;
   end

   // Score snapshot register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         snap_q <= '0;
      end else begin
         snap_q <= snap_d;
      end
   end

   // Glyph for the current slot, chosen by the game state
   always_comb begin
      glyph      = SEG_BLANK;
      showTens   = GAME_TENS;
      showUnits  = GAME_UNITS;
      scoreDigit = snap_q[{digitIdx_q[1:0], 2'b00} +: 4];
      leadZero   = 1'b0;
      if (inPlay) begin
         showTens  = timeTens_q;
         showUnits = timeUnits_q;
      end else if (inOver) begin
         showTens  = 4'd0;
         showUnits = 4'd0;
      end
      case (digitIdx_q)
         IDX_SC_THOU: leadZero = (snap_q[15:12] == 4'd0);
         IDX_SC_HUND: leadZero = (snap_q[15:8] == 8'd0);
         IDX_SC_TENS: leadZero = (snap_q[15:4] == 12'd0);
         default:     leadZero = 1'b0;
      endcase
      case (digitIdx_q)
         IDX_TIME_TENS: begin
            if (ZERO_BLANK && showTens == 4'd0) glyph = SEG_BLANK;
            else                                glyph = digitToSeg(showTens);
         end
         IDX_TIME_UNITS: glyph = digitToSeg(showUnits);
         IDX_BLANK_HI,
         IDX_BLANK_LO:   glyph = SEG_BLANK;
         default: begin
            if (!inPlay && !inOver)            glyph = SEG_DASH;
            else if (inOver && blinkPhase_q)   glyph = SEG_BLANK;
            else if (ZERO_BLANK && leadZero)   glyph = SEG_BLANK;
            else                               glyph = digitToSeg(scoreDigit);
         end
      endcase
   end

   // Registered anode and segment outputs; DP is never lit
   always_ff @(posedge clk) begin
      if (!rstn) begin
         an_q  <= 8'hFF;
         seg_q <= 8'hFF;
      end else begin
         an_q  <= ~(8'b1 << digitIdx_q);
         seg_q <= {1'b1, glyph};
      end
   end

   assign an  = an_q;
   assign seg = seg_q;

endmodule
